alu_sequencer: RTL and testbench

//   Multi-cycle control FSM for the ALU datapath. Accepts an operation request and

---
 rtl/alu_sequencer.sv | 96 +++++++++
 tb/tb_alu_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM for the ALU datapath. It drives the operand-load, execute and
// iterate strobes, the result-mux select, and a done pulse that coincides with the write.
`timescale 1ns/1ps

module alu_sequencer #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       opcode,
  input  logic             abort,
  output logic             busy,
  output logic             load_ops,
  output logic             exec_en,
  output logic             sub_en,
  output logic             iter_en,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       res_sel,
  output logic             write_en,
  output logic             done
);

  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StExec, StIter, StWrite} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       op_q, op_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      op_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
    end
  end

  // The counter defaults to zero so it only ever shows a non-zero value while in ITER.
  always_comb begin
    state_d = state_q;
    count_d = '0;
    op_d    = op_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          op_d    = opcode;
        end
      end
      StLoad: begin
        if (abort)        state_d = StIdle;
        else if (op_q[1]) state_d = StIter;
        else              state_d = StExec;
      end
      StExec: begin
        state_d = abort ? StIdle : StWrite;
      end
      StIter: begin
        if (abort) begin
          state_d = StIdle;
        end else if (count_q == LastIter) begin
          state_d = StWrite;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      StWrite: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    busy     = (state_q != StIdle);
    load_ops = (state_q == StLoad);
    exec_en  = (state_q == StExec);
    iter_en  = (state_q == StIter);
    write_en = (state_q == StWrite);
    done     = (state_q == StWrite);
    sub_en   = (op_q == OpSub);
    res_sel  = op_q;
    count    = count_q;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: inputs change and outputs are sampled on the falling
// edge, so each sample shows the state entered at the preceding rising edge.
`timescale 1ns/1ps

module tb_alu_sequencer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       opcode;
  logic             abort;
  logic             busy, load_ops, exec_en, sub_en, iter_en, write_en, done;
  logic [CNT_W-1:0] count;
  logic [1:0]       res_sel;

  int n_checks = 0;
  int n_pass   = 0;

  alu_sequencer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .opcode   (opcode),
    .abort    (abort),
    .busy     (busy),
    .load_ops (load_ops),
    .exec_en  (exec_en),
    .sub_en   (sub_en),
    .iter_en  (iter_en),
    .count    (count),
    .res_sel  (res_sel),
    .write_en (write_en),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Output vector: {busy, load_ops, exec_en, sub_en, iter_en, write_en, done, res_sel, count}
  function automatic logic [11:0] outs();
    return {busy, load_ops, exec_en, sub_en, iter_en, write_en, done, res_sel, count};
  endfunction

  function automatic logic [11:0] pk(input logic b, input logic l, input logic e,
                                     input logic s, input logic it, input logic w,
                                     input logic d, input logic [1:0] rs,
                                     input logic [2:0] c);
    return {b, l, e, s, it, w, d, rs, c};
  endfunction

  task automatic test_reset();
    logic [11:0] exp;
    rst = 1'b1; start = 1'b0; opcode = 2'b00; abort = 1'b0;
    @(negedge clk);
    exp = pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0);
    n_checks++;
    if (outs() !== exp) $display("FAIL reset_held: got %b want %b", outs(), exp);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outs() !== exp) $display("FAIL reset_idle: got %b want %b", outs(), exp);
    else n_pass++;
  endtask

  task automatic test_add();
    logic [11:0] exp [4];
    exp[0] = pk(1, 1, 0, 0, 0, 0, 0, 2'b00, 3'd0);
    exp[1] = pk(1, 0, 1, 0, 0, 0, 0, 2'b00, 3'd0);
    exp[2] = pk(1, 0, 0, 0, 0, 1, 1, 2'b00, 3'd0);
    exp[3] = pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0);
    start = 1'b1; opcode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (outs() !== exp[i]) $display("FAIL add_step%0d: got %b want %b", i, outs(), exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_mul();
    logic [11:0] exp;
    start = 1'b1; opcode = 2'b10;
    @(negedge clk);
    start = 1'b0;
    exp = pk(1, 1, 0, 0, 0, 0, 0, 2'b10, 3'd0);
    n_checks++;
    if (outs() !== exp) $display("FAIL mul_load: got %b want %b", outs(), exp);
    else n_pass++;
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      // A stray start/opcode mid-iteration must be ignored.
      start  = (i == 3);
      opcode = (i == 3) ? 2'b00 : 2'b10;
      exp = pk(1, 0, 0, 0, 1, 0, 0, 2'b10, 3'(i));
      n_checks++;
      if (outs() !== exp) $display("FAIL mul_iter%0d: got %b want %b", i, outs(), exp);
      else n_pass++;
    end
    @(negedge clk);
    exp = pk(1, 0, 0, 0, 0, 1, 1, 2'b10, 3'd0);
    n_checks++;
    if (outs() !== exp) $display("FAIL mul_write: got %b want %b", outs(), exp);
    else n_pass++;
    @(negedge clk);
    exp = pk(0, 0, 0, 0, 0, 0, 0, 2'b10, 3'd0);
    n_checks++;
    if (outs() !== exp) $display("FAIL mul_idle_hold: got %b want %b", outs(), exp);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp [4];
    exp[0] = pk(1, 1, 0, 1, 0, 0, 0, 2'b01, 3'd0);
    exp[1] = pk(1, 0, 1, 1, 0, 0, 0, 2'b01, 3'd0);
    exp[2] = pk(1, 0, 0, 1, 0, 1, 1, 2'b01, 3'd0);
    exp[3] = pk(0, 0, 0, 1, 0, 0, 0, 2'b01, 3'd0);
    start = 1'b1; opcode = 2'b01;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (k == 2 && i == 2) start = 1'b0;
        n_checks++;
        if (outs() !== exp[i])
          $display("FAIL b2b_op%0d_step%0d: got %b want %b", k, i, outs(), exp[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_abort_div();
    logic [11:0] exp;
    int          n_done;
    start = 1'b1; opcode = 2'b11;
    @(negedge clk);
    start = 1'b0;
    exp = pk(1, 1, 0, 0, 0, 0, 0, 2'b11, 3'd0);
    n_checks++;
    if (outs() !== exp) $display("FAIL div_load: got %b want %b", outs(), exp);
    else n_pass++;
    for (int i = 0; i < 4; i++) @(negedge clk);
    exp = pk(1, 0, 0, 0, 1, 0, 0, 2'b11, 3'd3);
    n_checks++;
    if (outs() !== exp) $display("FAIL div_iter3: got %b want %b", outs(), exp);
    else n_pass++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    exp = pk(0, 0, 0, 0, 0, 0, 0, 2'b11, 3'd0);
    n_checks++;
    if (outs() !== exp) $display("FAIL div_abort_idle: got %b want %b", outs(), exp);
    else n_pass++;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || write_en || busy) n_done++;
    end
    n_checks++;
    if (n_done !== 0) $display("FAIL div_abort_quiet: got %0d active cycles want 0", n_done);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [11:0] exp;
    start = 1'b1; opcode = 2'b10;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    exp = pk(1, 0, 0, 0, 1, 0, 0, 2'b10, 3'd2);
    n_checks++;
    if (outs() !== exp) $display("FAIL rst_pre_iter2: got %b want %b", outs(), exp);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    exp = pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0);
    n_checks++;
    if (outs() !== exp) $display("FAIL rst_async_immediate: got %b want %b", outs(), exp);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1; opcode = 2'b01;
    @(negedge clk);
    start = 1'b0;
    exp = pk(1, 1, 0, 1, 0, 0, 0, 2'b01, 3'd0);
    n_checks++;
    if (outs() !== exp) $display("FAIL rst_restart_load: got %b want %b", outs(), exp);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    exp = pk(1, 0, 0, 1, 0, 1, 1, 2'b01, 3'd0);
    n_checks++;
    if (outs() !== exp) $display("FAIL rst_restart_write: got %b want %b", outs(), exp);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_abort_write();
    logic [11:0] exp;
    start = 1'b1; opcode = 2'b00;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    exp = pk(1, 0, 0, 0, 0, 1, 1, 2'b00, 3'd0);
    n_checks++;
    if (outs() !== exp) $display("FAIL abort_write_done: got %b want %b", outs(), exp);
    else n_pass++;
    @(negedge clk);
    exp = pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0);
    n_checks++;
    if (outs() !== exp) $display("FAIL abort_write_idle: got %b want %b", outs(), exp);
    else n_pass++;
    // abort still high together with start in IDLE: start must win.
    start = 1'b1; opcode = 2'b11;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    exp = pk(1, 1, 0, 0, 0, 0, 0, 2'b11, 3'd0);
    n_checks++;
    if (outs() !== exp) $display("FAIL abort_start_load: got %b want %b", outs(), exp);
    else n_pass++;
    for (int i = 0; i < WIDTH + 1; i++) @(negedge clk);
    exp = pk(1, 0, 0, 0, 0, 1, 1, 2'b11, 3'd0);
    n_checks++;
    if (outs() !== exp) $display("FAIL abort_start_div_write: got %b want %b", outs(), exp);
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_back_to_back();
    test_abort_div();
    test_async_reset();
    test_abort_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
